// File: rtl/evm_pkg.sv
// Shared types and defaults for the vote logger.
// Optional build macro used by this block: DEBOUNCE_EN (per-button debounce filter).
package evm_pkg;

    localparam int unsigned NUM_CAND                = 4;
    localparam int unsigned CAND_IDX_W              = 2;
    localparam int unsigned CNT_W_DEFAULT           = 4;
    localparam int unsigned LOCKOUT_CYCLES_DEFAULT  = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        VOTE,
        WAIT_RELEASE,
        LOCKOUT
    } state_e;

    // Index of the set bit; only meaningful when exactly one bit is set.
    function automatic logic [CAND_IDX_W-1:0] onehot_to_idx(input logic [NUM_CAND-1:0] onehot);
        logic [CAND_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (onehot[i]) idx = CAND_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// One candidate button: 2-FF synchroniser, optionally followed by a debounce filter.
// Build macro: DEBOUNCE_EN enables the filter; without it the synchroniser output is used directly.
module button_conditioner
    import evm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_btn
);

    if (DEBOUNCE_CYCLES < 1) begin : g_param_chk
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic r_sync1;
    logic r_sync2;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn;

    // Accept a new level only after it has been seen on DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_db_cnt <= '0;
            r_btn    <= 1'b0;
        end else if (r_sync2 == r_btn) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_btn    <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign o_btn = r_btn;
`else
    assign o_btn = r_sync2;
`endif

endmodule

// File: rtl/vote_logger.sv
// Vote logger: conditions four candidate buttons, accepts one vote per press,
// keeps saturating per-candidate tallies and a sticky overflow flag.
// Build macro: DEBOUNCE_EN adds a debounce filter after each synchroniser.
module vote_logger
    import evm_pkg::*;
#(
    parameter int unsigned CNT_W           = CNT_W_DEFAULT,
    parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode,
    input  logic             candidate1_button_press,
    input  logic             candidate2_button_press,
    input  logic             candidate3_button_press,
    input  logic             candidate4_button_press,
    output logic             valid_vote_casted,
    output logic [CNT_W-1:0] candidate1_votes,
    output logic [CNT_W-1:0] candidate2_votes,
    output logic [CNT_W-1:0] candidate3_votes,
    output logic [CNT_W-1:0] candidate4_votes,
    output logic             vote_overflow
);

    if (LOCKOUT_CYCLES < 1) begin : g_param_chk
        $error("LOCKOUT_CYCLES must be at least 1");
    end

    localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TALLY_MAX = '1;

    logic [NUM_CAND-1:0]   w_raw;
    logic [NUM_CAND-1:0]   w_btn;

    state_e                r_state;
    state_e                w_state_next;
    logic [LOCK_W-1:0]     r_lock_cnt;
    logic [LOCK_W-1:0]     w_lock_cnt_next;
    logic [CAND_IDX_W-1:0] r_idx;
    logic [CAND_IDX_W-1:0] w_idx_next;

    logic [CNT_W-1:0]      r_tally [NUM_CAND];
    logic                  r_valid;
    logic                  r_overflow;
    logic                  w_vote_ok;

    assign w_raw = {candidate4_button_press, candidate3_button_press,
                    candidate2_button_press, candidate1_button_press};

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_cond
        button_conditioner #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cond (
            .clock (clock),
            .reset (reset),
            .i_raw (w_raw[i]),
            .o_btn (w_btn[i])
        );
    end

    // FSM state, lockout counter and latched candidate index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_cnt <= w_lock_cnt_next;
            r_idx      <= w_idx_next;
        end
    end

    // Next-state logic: one vote per press, then wait for release and a quiet period.
    always_comb begin
        w_state_next    = r_state;
        w_lock_cnt_next = r_lock_cnt;
        w_idx_next      = r_idx;
        unique case (r_state)
            IDLE: begin
                if (!mode) begin
                    if ($onehot(w_btn)) begin
                        w_idx_next   = onehot_to_idx(w_btn);
                        w_state_next = VOTE;
                    end else if (|w_btn) begin
                        // Ambiguous press: record nothing but still demand a release.
                        w_state_next = WAIT_RELEASE;
                    end
                end
            end
            VOTE: begin
                w_state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (w_btn == '0) begin
                    w_lock_cnt_next = '0;
                    w_state_next    = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (r_lock_cnt == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                    w_lock_cnt_next = '0;
                    w_state_next    = IDLE;
                end else begin
                    w_lock_cnt_next = r_lock_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_vote_ok = (r_tally[r_idx] != TALLY_MAX);

    // Record the vote in the VOTE cycle; tally and pulse change on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                r_tally[i] <= '0;
            end
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == VOTE) begin
                if (w_vote_ok) begin
                    r_tally[r_idx] <= r_tally[r_idx] + 1'b1;
                    r_valid        <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign valid_vote_casted = r_valid;
    assign vote_overflow     = r_overflow;
    assign candidate1_votes  = r_tally[0];
    assign candidate2_votes  = r_tally[1];
    assign candidate3_votes  = r_tally[2];
    assign candidate4_votes  = r_tally[3];

endmodule

// File: tb/tb_vote_logger.sv
// Self-checking bench for vote_logger (default build, DEBOUNCE_EN undefined).
module tb_vote_logger;

    localparam int LOCK = 10;
    localparam int MAXV = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode  = 1'b0;
    logic       b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, b4 = 1'b0;
    logic       valid_vote_casted;
    logic [3:0] v1, v2, v3, v4;
    logic       vote_overflow;

    always #5 clock = ~clock;

    vote_logger dut (
        .clock                   (clock),
        .reset                   (reset),
        .mode                    (mode),
        .candidate1_button_press (b1),
        .candidate2_button_press (b2),
        .candidate3_button_press (b3),
        .candidate4_button_press (b4),
        .valid_vote_casted       (valid_vote_casted),
        .candidate1_votes        (v1),
        .candidate2_votes        (v2),
        .candidate3_votes        (v3),
        .candidate4_votes        (v4),
        .vote_overflow           (vote_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_seen;

    // Reference model: a vote is a single-button press seen two edges late,
    // after which the logger is busy until release plus LOCK quiet edges.
    logic [3:0] m_s1, m_s2;
    int         m_pending;
    bit         m_wait;
    int         m_lock;
    int         m_tally [4];
    bit         m_pulse;
    bit         m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_pending = -1; m_wait = 0; m_lock = 0;
        m_pulse = 0; m_ovf = 0;
        for (int i = 0; i < 4; i++) m_tally[i] = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic m);
        logic [3:0] b;
        b = m_s2;
        m_pulse = 0;
        if (m_pending >= 0) begin
            if (m_tally[m_pending] < MAXV) begin
                m_tally[m_pending]++;
                m_pulse = 1;
            end else begin
                m_ovf = 1;
            end
            m_pending = -1;
            m_wait = 1;
        end else if (m_wait) begin
            if (b == 4'b0000) begin
                m_wait = 0;
                m_lock = LOCK;
            end
        end else if (m_lock > 0) begin
            m_lock--;
        end else if (!m) begin
            if ($countones(b) == 1) begin
                for (int i = 0; i < 4; i++) if (b[i]) m_pending = i;
            end else if (b != 4'b0000) begin
                m_wait = 1;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic check_all();
        chk("cyc_pulse", valid_vote_casted, m_pulse);
        chk("cyc_tally1", v1, m_tally[0]);
        chk("cyc_tally2", v2, m_tally[1]);
        chk("cyc_tally3", v3, m_tally[2]);
        chk("cyc_tally4", v4, m_tally[3]);
        chk("cyc_overflow", vote_overflow, m_ovf);
    endtask

    // Drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
    task automatic cycle(input logic [3:0] raw, input logic m);
        {b4, b3, b2, b1} = raw;
        mode = m;
        @(posedge clock);
        if (reset === 1'b0) model_reset();
        else model_edge(raw, m);
        @(negedge clock);
        cyc++;
        check_all();
        if (valid_vote_casted === 1'b1) pulse_seen++;
    endtask

    task automatic press(input logic [3:0] raw, input logic m, input int hold, input int gap);
        for (int k = 0; k < hold; k++) cycle(raw, m);
        for (int k = 0; k < gap; k++) cycle(4'b0000, m);
    endtask

    // Press one button for 5 cycles; the pulse must appear on the third edge after first sampling.
    task automatic latency_check(input int idx, input string name);
        logic [3:0] raw;
        int first;
        raw = 4'b0001 << idx;
        first = -1;
        pulse_seen = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(raw, 1'b0);
            if (valid_vote_casted === 1'b1 && first < 0) first = k;
        end
        for (int k = 0; k < 20; k++) cycle(4'b0000, 1'b0);
        chk({name, "_pulse_edge"}, first, 3);
        chk({name, "_pulse_count"}, pulse_seen, 1);
    endtask

    typedef struct {
        logic [3:0] raw;
        logic       m;
        int         hold;
        int         gap;
        int         exp_pulses;
        int         t1, t2, t3, t4;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [3:0] raw;
        logic       m;

        tbl[0] = '{4'b0001, 1'b0, 50, 3,  1, 1, 1, 0, 0}; // long hold counts once
        tbl[1] = '{4'b0001, 1'b0, 2,  20, 0, 1, 1, 0, 0}; // press inside lockout ignored
        tbl[2] = '{4'b0001, 1'b0, 5,  20, 1, 2, 1, 0, 0}; // after lockout accepted
        tbl[3] = '{4'b0101, 1'b0, 5,  4,  0, 2, 1, 0, 0}; // two buttons: no vote
        tbl[4] = '{4'b0010, 1'b0, 3,  20, 0, 2, 1, 0, 0}; // still locked after multi-press
        tbl[5] = '{4'b1000, 1'b1, 5,  20, 0, 2, 1, 0, 0}; // result mode ignores buttons
        tbl[6] = '{4'b1000, 1'b0, 5,  20, 1, 2, 1, 0, 1}; // back in voting mode
        tbl[7] = '{4'b0100, 1'b0, 1,  16, 1, 2, 1, 1, 1}; // single-cycle press
        tbl[8] = '{4'b0100, 1'b1, 5,  20, 0, 2, 1, 1, 1}; // tallies held in result mode

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b0;
        @(negedge clock);
        model_reset();
        chk("rst_pulse", valid_vote_casted, 1'b0);
        chk("rst_tally1", v1, 4'd0);
        chk("rst_tally2", v2, 4'd0);
        chk("rst_tally3", v3, 4'd0);
        chk("rst_tally4", v4, 4'd0);
        chk("rst_overflow", vote_overflow, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        latency_check(1, "first_vote");
        chk("first_vote_tally2", v2, 4'd1);
        chk("first_vote_tally1", v1, 4'd0);

        for (int i = 0; i < 9; i++) begin
            pulse_seen = 0;
            press(tbl[i].raw, tbl[i].m, tbl[i].hold, tbl[i].gap);
            chk($sformatf("vec%0d_pulses", i), pulse_seen, tbl[i].exp_pulses);
            chk($sformatf("vec%0d_tally1", i), v1, tbl[i].t1);
            chk($sformatf("vec%0d_tally2", i), v2, tbl[i].t2);
            chk($sformatf("vec%0d_tally3", i), v3, tbl[i].t3);
            chk($sformatf("vec%0d_tally4", i), v4, tbl[i].t4);
        end

        // Reset asserted asynchronously in the middle of LOCKOUT.
        pulse_seen = 0;
        press(4'b0001, 1'b0, 3, 5);
        chk("pre_reset_pulses", pulse_seen, 1);
        chk("pre_reset_tally1", v1, 4'd3);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pulse", valid_vote_casted, 1'b0);
        chk("async_rst_tally1", v1, 4'd0);
        chk("async_rst_tally2", v2, 4'd0);
        chk("async_rst_tally3", v3, 4'd0);
        chk("async_rst_tally4", v4, 4'd0);
        chk("async_rst_overflow", vote_overflow, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        latency_check(1, "post_reset_vote");
        chk("post_reset_tally2", v2, 4'd1);

        // Saturation on candidate 1.
        for (int i = 0; i < 16; i++) begin
            pulse_seen = 0;
            press(4'b0001, 1'b0, 3, 16);
            chk($sformatf("sat%0d_pulses", i), pulse_seen, (i < 15) ? 1 : 0);
            if (i == 14) chk("sat_before_overflow", vote_overflow, 1'b0);
        end
        chk("sat_tally1", v1, 4'd15);
        chk("sat_overflow", vote_overflow, 1'b1);

        // Randomised presses against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) raw = 4'($urandom_range(1, 15));
            else raw = 4'b0001 << $urandom_range(0, 3);
            m = ($urandom_range(0, 4) == 0);
            press(raw, m, $urandom_range(1, 8), $urandom_range(0, 14));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
